// File: rtl/trap_ctrl.sv
// trap_ctrl - machine-mode trap sequencer feeding the csr block write port.
//
// Takes synchronous exceptions, MRET and masked M-mode interrupts, then
// performs the CSR updates one write at a time through a single write port
// and finishes with a one-cycle PC redirect. o_busy stalls the pipeline for
// the whole sequence.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_exc_*, i_pc           exception request, cause code, mtval value, PC
//   i_mret                  MRET retiring
//   i_irq_msip/mtip/meip    raw interrupt pending lines
//   i_mstatus/mie/mtvec/mepc current CSR values
//   i_csr_ready             csr block accepts the current write
//   o_csr_we/addr/wdata     csr write port
//   o_busy                  sequence in progress
//   o_redirect_valid/pc     one-cycle fetch redirect
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | waiting; arbitrates exception > MRET > interrupt
// WR_MEPC     | writing saved PC to mepc
// WR_MCAUSE   | writing cause to mcause
// WR_MTVAL    | writing faulting value to mtval
// WR_MSTATUS  | writing trap-entry mstatus
// MRET_STATUS | writing MRET-exit mstatus
// REDIRECT    | one-cycle redirect strobe, then back to IDLE

module trap_ctrl #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342,
    parameter logic [11:0] CSR_MTVAL   = 12'h343
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_mret,
    input  logic            i_irq_msip,
    input  logic            i_irq_mtip,
    input  logic            i_irq_meip,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_csr_ready,
    output logic            o_csr_we,
    output logic [11:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_busy,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc
);

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MCAUSE,
        WR_MTVAL,
        WR_MSTATUS,
        MRET_STATUS,
        REDIRECT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] target_q, target_d;

    logic            irq_valid;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] tvec_base;

    // Bits of the CSR inputs this block never looks at.
    logic unused_bits;
    assign unused_bits = ^{i_mie[XLEN-1:12], i_mie[10:8], i_mie[6:4],
                           i_mie[2:0], i_mepc[1:0]};

    assign tvec_base = {i_mtvec[XLEN-1:2], 2'b00};

    // Interrupt selection: global MIE gates everything; MEI > MSI > MTI.
    always_comb begin
        irq_valid = 1'b0;
        irq_code  = 4'd0;
        if (i_mstatus[3]) begin
            if (i_irq_meip && i_mie[11]) begin
                irq_valid = 1'b1;
                irq_code  = 4'd11;
            end else if (i_irq_msip && i_mie[3]) begin
                irq_valid = 1'b1;
                irq_code  = 4'd3;
            end else if (i_irq_mtip && i_mie[7]) begin
                irq_valid = 1'b1;
                irq_code  = 4'd7;
            end
        end
    end

    // Next-state and latched-field logic.
    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        mstatus_d = mstatus_q;
        target_d  = target_q;

        case (state_q)
            IDLE: begin
                if (i_exc_valid || (!i_mret && irq_valid)) begin
                    epc_d         = i_pc;
                    cause_d       = '0;
                    mstatus_d     = i_mstatus;
                    mstatus_d[7]  = i_mstatus[3];
                    mstatus_d[3]  = 1'b0;
                    mstatus_d[12:11] = 2'b11;
                    if (i_exc_valid) begin
                        cause_d[3:0] = i_exc_code;
                        tval_d       = i_exc_tval;
                        target_d     = tvec_base;
                    end else begin
                        cause_d[XLEN-1] = 1'b1;
                        cause_d[3:0]    = irq_code;
                        tval_d          = '0;
                        // Vectored mode only for interrupts; modes 10/11 act as direct.
                        if (i_mtvec[1:0] == 2'b01)
                            target_d = tvec_base + XLEN'({irq_code, 2'b00});
                        else
                            target_d = tvec_base;
                    end
                    state_d = WR_MEPC;
                end else if (i_mret) begin
                    mstatus_d        = i_mstatus;
                    mstatus_d[3]     = i_mstatus[7];
                    mstatus_d[7]     = 1'b1;
                    mstatus_d[12:11] = 2'b11;
                    target_d         = {i_mepc[XLEN-1:2], 2'b00};
                    state_d          = MRET_STATUS;
                end
            end
            WR_MEPC:     if (i_csr_ready) state_d = WR_MCAUSE;
            WR_MCAUSE:   if (i_csr_ready) state_d = WR_MTVAL;
            WR_MTVAL:    if (i_csr_ready) state_d = WR_MSTATUS;
            WR_MSTATUS:  if (i_csr_ready) state_d = REDIRECT;
            MRET_STATUS: if (i_csr_ready) state_d = REDIRECT;
            REDIRECT:    state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs are decoded purely from state so they hold steady under backpressure.
    always_comb begin
        o_csr_we         = 1'b0;
        o_csr_addr       = 12'h000;
        o_csr_wdata      = '0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_busy           = (state_q != IDLE);

        case (state_q)
            WR_MEPC: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = epc_q;
            end
            WR_MCAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = cause_q;
            end
            WR_MTVAL: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MTVAL;
                o_csr_wdata = tval_q;
            end
            WR_MSTATUS, MRET_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = mstatus_q;
            end
            REDIRECT: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            mstatus_q <= mstatus_d;
            target_q  <= target_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl - vector table plus hand sequences for trap_ctrl.
// Expected CSR writes and redirects are queued when a request is driven and
// popped by a monitor on the falling edge when the DUT presents them.

module tb_trap_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_exc_valid;
    logic [3:0]  i_exc_code;
    logic [31:0] i_exc_tval;
    logic [31:0] i_pc;
    logic        i_mret;
    logic        i_irq_msip, i_irq_mtip, i_irq_meip;
    logic [31:0] i_mstatus, i_mie, i_mtvec, i_mepc;
    logic        i_csr_ready;
    logic        o_csr_we;
    logic [11:0] o_csr_addr;
    logic [31:0] o_csr_wdata;
    logic        o_busy;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    always #5 i_clk = ~i_clk;

    trap_ctrl dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_exc_valid      (i_exc_valid),
        .i_exc_code       (i_exc_code),
        .i_exc_tval       (i_exc_tval),
        .i_pc             (i_pc),
        .i_mret           (i_mret),
        .i_irq_msip       (i_irq_msip),
        .i_irq_mtip       (i_irq_mtip),
        .i_irq_meip       (i_irq_meip),
        .i_mstatus        (i_mstatus),
        .i_mie            (i_mie),
        .i_mtvec          (i_mtvec),
        .i_mepc           (i_mepc),
        .i_csr_ready      (i_csr_ready),
        .o_csr_we         (o_csr_we),
        .o_csr_addr       (o_csr_addr),
        .o_csr_wdata      (o_csr_wdata),
        .o_busy           (o_busy),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc)
    );

    typedef struct {
        logic        exc_valid;
        logic [3:0]  exc_code;
        logic [31:0] exc_tval;
        logic [31:0] pc;
        logic        mret;
        logic        msip, mtip, meip;
        logic [31:0] mstatus, mie, mtvec, mepc;
        int          kind;     // 0 no action, 1 trap, 2 mret
        logic [31:0] e_cause, e_tval, e_ms, e_tgt;
    } vec_t;

    typedef struct {
        logic        is_redir;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t  exp_q[$];
    vec_t vecs[$];
    ev_t  mon_ev;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic ev, input logic [3:0] code,
                                input logic [31:0] tval, input logic [31:0] pc,
                                input logic mret, input logic msip,
                                input logic mtip, input logic meip,
                                input logic [31:0] ms, input logic [31:0] mie,
                                input logic [31:0] mtvec, input logic [31:0] mepc,
                                input int kind, input logic [31:0] e_cause,
                                input logic [31:0] e_tval, input logic [31:0] e_ms,
                                input logic [31:0] e_tgt);
        vec_t v;
        v.exc_valid = ev;   v.exc_code = code; v.exc_tval = tval; v.pc = pc;
        v.mret = mret;      v.msip = msip;     v.mtip = mtip;     v.meip = meip;
        v.mstatus = ms;     v.mie = mie;       v.mtvec = mtvec;   v.mepc = mepc;
        v.kind = kind;      v.e_cause = e_cause; v.e_tval = e_tval;
        v.e_ms = e_ms;      v.e_tgt = e_tgt;
        return v;
    endfunction

    // Monitor: every accepted write / redirect must match the queue head.
    always @(negedge i_clk) begin
        if (o_csr_we && i_csr_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write addr=0x%03h data=0x%08h required=none",
                         o_csr_addr, o_csr_wdata);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("event_is_write", 32'(mon_ev.is_redir), 32'd0);
                chk("csr_addr", {20'd0, o_csr_addr}, {20'd0, mon_ev.addr});
                chk("csr_wdata", o_csr_wdata, mon_ev.data);
            end
        end
        if (o_redirect_valid) begin
            chk("redirect_no_we", 32'(o_csr_we), 32'd0);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_redirect pc=0x%08h required=none", o_redirect_pc);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("event_is_redirect", 32'(mon_ev.is_redir), 32'd1);
                chk("redirect_pc", o_redirect_pc, mon_ev.data);
            end
        end
        if (!o_csr_we)
            chk("idle_csr_fields_zero", {20'd0, o_csr_addr} | o_csr_wdata, 32'd0);
        if (!o_redirect_valid)
            chk("idle_redirect_pc_zero", o_redirect_pc, 32'd0);
    end

    task automatic clear_req();
        i_exc_valid = 1'b0;
        i_mret      = 1'b0;
        i_irq_msip  = 1'b0;
        i_irq_mtip  = 1'b0;
        i_irq_meip  = 1'b0;
    endtask

    task automatic push_ev(input logic r, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.is_redir = r; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_expect(input vec_t v);
        if (v.kind == 1) begin
            push_ev(1'b0, 12'h341, v.pc);
            push_ev(1'b0, 12'h342, v.e_cause);
            push_ev(1'b0, 12'h343, v.e_tval);
            push_ev(1'b0, 12'h300, v.e_ms);
            push_ev(1'b1, 12'h000, v.e_tgt);
        end else if (v.kind == 2) begin
            push_ev(1'b0, 12'h300, v.e_ms);
            push_ev(1'b1, 12'h000, v.e_tgt);
        end
    endtask

    // Drive a request for exactly one accepting edge; returns 2ns after that edge.
    task automatic apply(input vec_t v);
        @(posedge i_clk); #2;
        push_expect(v);
        i_exc_valid = v.exc_valid; i_exc_code = v.exc_code; i_exc_tval = v.exc_tval;
        i_pc = v.pc; i_mret = v.mret;
        i_irq_msip = v.msip; i_irq_mtip = v.mtip; i_irq_meip = v.meip;
        i_mstatus = v.mstatus; i_mie = v.mie; i_mtvec = v.mtvec; i_mepc = v.mepc;
        @(posedge i_clk); #2;
        clear_req();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d busy=%0d required=0 pending, idle",
                     name, exp_q.size(), o_busy);
            exp_q.delete();
        end
    endtask

    initial begin
        int   red_at, busy_cnt;
        vec_t v;

        i_rst = 1'b1;
        clear_req();
        i_exc_valid = 1'b1; i_exc_code = 4'd11; i_exc_tval = '0; i_pc = 32'h100;
        i_mstatus = 32'h8; i_mie = '0; i_mtvec = 32'h80; i_mepc = '0;
        i_csr_ready = 1'b1;

        // Reset holds everything off even with an exception pending.
        repeat (2) begin
            @(negedge i_clk);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_we", 32'(o_csr_we), 32'd0);
            chk("rst_redirect", 32'(o_redirect_valid), 32'd0);
        end
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        clear_req();

        vecs.push_back(mk(1,11,32'h0,32'h100, 0,0,0,0, 32'h8,32'h0,32'h80,32'h0,
                          1, 32'hB,32'h0,32'h1880,32'h80));
        vecs.push_back(mk(0,0,32'h0,32'h2000, 0,0,1,0, 32'h8,32'h80,32'h201,32'h0,
                          1, 32'h80000007,32'h0,32'h1880,32'h21C));
        vecs.push_back(mk(0,0,32'h0,32'h3000, 0,1,1,1, 32'h0,32'h888,32'h201,32'h0,
                          0, 32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,32'h3000, 0,0,1,1, 32'h8,32'h888,32'h201,32'h0,
                          1, 32'h8000000B,32'h0,32'h1880,32'h22C));
        vecs.push_back(mk(1,2,32'hDEADBEEF,32'h400, 0,0,0,1, 32'h8,32'h800,32'h201,32'h0,
                          1, 32'h2,32'hDEADBEEF,32'h1880,32'h200));
        vecs.push_back(mk(0,0,32'h0,32'h0, 1,0,0,0, 32'h1880,32'h0,32'h0,32'h102,
                          2, 32'h0,32'h0,32'h1888,32'h100));
        vecs.push_back(mk(0,0,32'h0,32'h600, 0,1,1,0, 32'h8,32'h88,32'h101,32'h0,
                          1, 32'h80000003,32'h0,32'h1880,32'h10C));
        vecs.push_back(mk(0,0,32'h0,32'h600, 0,0,1,0, 32'h8,32'h8,32'h101,32'h0,
                          0, 32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(1,3,32'h500,32'h500, 1,0,0,0, 32'h80,32'h0,32'h3,32'h0,
                          1, 32'h3,32'h500,32'h1800,32'h0));
        vecs.push_back(mk(0,0,32'h0,32'h700, 0,1,0,0, 32'h8,32'h8,32'h1002,32'h0,
                          1, 32'h80000003,32'h0,32'h1880,32'h1000));
        vecs.push_back(mk(0,0,32'h0,32'h0, 1,0,0,0, 32'h8,32'h0,32'h0,32'h203,
                          2, 32'h0,32'h0,32'h1880,32'h200));
        vecs.push_back(mk(0,0,32'h0,32'h800, 1,0,0,1, 32'h88,32'h800,32'h201,32'hFFFFFFFC,
                          2, 32'h0,32'h0,32'h1888,32'hFFFFFFFC));
        vecs.push_back(mk(0,0,32'h0,32'h900, 0,0,0,1, 32'hA0000008,32'h800,32'hFFFFFFF1,32'h0,
                          1, 32'h8000000B,32'h0,32'hA0001880,32'h1C));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (vecs[i].kind == 0) begin
                repeat (3) begin
                    @(negedge i_clk);
                    chk($sformatf("vec%0d_no_action_busy", i), 32'(o_busy), 32'd0);
                end
            end else begin
                wait_done($sformatf("vec%0d", i));
            end
        end

        // Trap latency with ready tied high: redirect in the 5th cycle after accept.
        v = vecs[0];
        apply(v);
        red_at = 0; busy_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (o_busy) busy_cnt++;
            if (o_redirect_valid && red_at == 0) red_at = k;
        end
        chk("trap_redirect_cycle", 32'(red_at), 32'd5);
        chk("trap_busy_cycles", 32'(busy_cnt), 32'd5);
        wait_done("trap_latency");

        // MRET latency: redirect in the 2nd cycle after accept.
        v = vecs[5];
        apply(v);
        red_at = 0; busy_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            if (o_busy) busy_cnt++;
            if (o_redirect_valid && red_at == 0) red_at = k;
        end
        chk("mret_redirect_cycle", 32'(red_at), 32'd2);
        chk("mret_busy_cycles", 32'(busy_cnt), 32'd2);
        wait_done("mret_latency");

        // Backpressure in WR_MCAUSE: outputs hold, no advance.
        apply(v.kind == 2 ? vecs[0] : vecs[0]);
        @(posedge i_clk); #2;
        i_csr_ready = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("bp_we_held", 32'(o_csr_we), 32'd1);
            chk("bp_addr_held", {20'd0, o_csr_addr}, 32'h342);
            chk("bp_data_held", o_csr_wdata, 32'hB);
        end
        @(posedge i_clk); #2;
        i_csr_ready = 1'b1;
        wait_done("backpressure");

        // Reset during WR_MTVAL: mtval write completes, nothing after it.
        @(posedge i_clk); #2;
        i_exc_valid = 1'b1; i_exc_code = 4'd11; i_exc_tval = '0; i_pc = 32'h100;
        i_mstatus = 32'h8; i_mtvec = 32'h80;
        push_ev(1'b0, 12'h341, 32'h100);
        push_ev(1'b0, 12'h342, 32'hB);
        push_ev(1'b0, 12'h343, 32'h0);
        @(posedge i_clk); #2;
        clear_req();
        @(posedge i_clk); #2;
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        @(posedge i_clk); #2;
        i_rst = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            chk("rst_mid_busy", 32'(o_busy), 32'd0);
        end
        chk("rst_mid_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
